button_debounce: RTL and testbench



---
 rtl/button_debounce_pkg.sv | 33 +++
 rtl/button_debounce.sv | 108 ++++++++++
 tb/tb_button_debounce.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/button_debounce_pkg.sv
// Shared types and helpers for the push-button debouncer: FSM state encoding
// and the debounce window length calculation.
package button_debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    PEND_HI   = 2'd1,
    STABLE_HI = 2'd2,
    PEND_LO   = 2'd3
  } debounce_state_t;

  // Window length in clock cycles; never below 1 so the FSM always has a
  // reachable terminal count, even for silly parameter combinations.
  function automatic int unsigned window_len(input int unsigned clk_freq,
                                             input int unsigned debounce_hz);
    int unsigned n;
    if (debounce_hz == 0) begin
      n = 1;
    end else begin
      n = clk_freq / debounce_hz;
    end
    if (n < 1) begin
      n = 1;
    end
    return n;
  endfunction

  // States in which the debounced level is high.
  function automatic logic is_high_state(input debounce_state_t s);
    return (s == STABLE_HI) || (s == PEND_LO);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Push-button debouncer: two-flop synchroniser feeding a four-state FSM that
// commits a new level only after it has been held for a full window.
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 1_000,
  parameter int unsigned DEBOUNCE_HZ = 40
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_out
);

  localparam int unsigned N     = window_len(CLK_FREQ, DEBOUNCE_HZ);
  localparam int          CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] CNT_N    = CNT_W'(N);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  logic            sync1_reg;
  logic            sync2_reg;
  debounce_state_t state_reg;
  debounce_state_t state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic            btn_out_reg;
  logic            btn_out_next;
  logic            sample_hi;

  // Anything other than a clean 1 (including X/Z in simulation) counts as low.
  assign sample_hi = (sync2_reg == 1'b1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg   <= 1'b0;
      sync2_reg   <= 1'b0;
      state_reg   <= STABLE_LO;
      cnt_reg     <= CNT_ZERO;
      btn_out_reg <= 1'b0;
    end else begin
      sync1_reg   <= btn_in;
      sync2_reg   <= sync1_reg;
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      btn_out_reg <= btn_out_next;
    end
  end

  // The counter stops at N because reaching N always leaves the PEND state.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      STABLE_LO: begin
        if (sample_hi) begin
          state_next = PEND_HI;
          cnt_next   = CNT_ONE;
        end else begin
          cnt_next   = CNT_ZERO;
        end
      end
      PEND_HI: begin
        if (!sample_hi) begin
          state_next = STABLE_LO;
          cnt_next   = CNT_ZERO;
        end else if (cnt_reg == CNT_N) begin
          state_next = STABLE_HI;
          cnt_next   = CNT_ZERO;
        end else begin
          cnt_next   = cnt_reg + CNT_ONE;
        end
      end
      STABLE_HI: begin
        if (!sample_hi) begin
          state_next = PEND_LO;
          cnt_next   = CNT_ONE;
        end else begin
          cnt_next   = CNT_ZERO;
        end
      end
      PEND_LO: begin
        if (sample_hi) begin
          state_next = STABLE_HI;
          cnt_next   = CNT_ZERO;
        end else if (cnt_reg == CNT_N) begin
          state_next = STABLE_LO;
          cnt_next   = CNT_ZERO;
        end else begin
          cnt_next   = cnt_reg + CNT_ONE;
        end
      end
      default: begin
        state_next = STABLE_LO;
        cnt_next   = CNT_ZERO;
      end
    endcase
  end

  // Output register is loaded from the next state so the level commits on
  // the same edge the FSM enters its new STABLE state.
  always_comb begin
    btn_out_next = is_high_state(state_next);
  end

  assign btn_out = btn_out_reg;

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce (N = 25): stimulus pushes expected
// output transitions, a monitor checks every btn_out change against them.
module tb_button_debounce;

  typedef struct {
    int   cyc;
    logic val;
  } exp_t;

  logic clk;
  logic rst;
  logic btn_in;
  logic btn_out;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   mon_en = 1'b0;
  exp_t exp_q[$];
  logic mon_v;
  exp_t mon_e;
  int   s;

  button_debounce #(
    .CLK_FREQ   (1000),
    .DEBOUNCE_HZ(40)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .btn_in (btn_in),
    .btn_out(btn_out)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d (cyc %0d)", name, act, want, cyc);
    end
  endtask

  task automatic push_exp(input int c, input logic v);
    exp_t e;
    e.cyc = c;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every output transition must match the next expected event.
  always @(btn_out) begin
    if (mon_en) begin
      mon_v = btn_out;
      #1;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_edge got=%0b at cyc=%0d want=no change", mon_v, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        $display("event cyc=%0d btn_out=%0b (expected cyc=%0d val=%0b)",
                 cyc, mon_v, mon_e.cyc, mon_e.val);
        check("edge_cyc", cyc, mon_e.cyc);
        check("edge_val", {31'd0, mon_v}, {31'd0, mon_e.val});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with an undefined pin: output low immediately and throughout.
    rst    = 1'b1;
    btn_in = 1'bx;
    #1;
    check("rst_imm", btn_out, 0);
    repeat (4) begin
      tick(1);
      check("rst_hold", btn_out, 0);
    end
    btn_in = 1'b0;
    rst    = 1'b0;
    mon_en = 1'b1;
    tick(5);
    check("rst_release", btn_out, 0);

    // Clean press: rises on the 28th edge after the step.
    btn_in = 1'b1;
    s = cyc;
    push_exp(s + 28, 1'b1);
    tick(27);
    check("press_pre", btn_out, 0);
    tick(1);
    check("press_edge", btn_out, 1);
    tick(12);
    check("press_hold", btn_out, 1);

    // Release with a 5-cycle high glitch at cycle 15 restarting the window.
    btn_in = 1'b0;
    tick(15);
    btn_in = 1'b1;
    tick(5);
    btn_in = 1'b0;
    s = cyc;
    push_exp(s + 28, 1'b0);
    tick(27);
    check("release_pre", btn_out, 1);
    tick(1);
    check("release_edge", btn_out, 0);
    tick(10);

    // Bouncy input: 10-cycle levels with sub-cycle glitches, never commits.
    for (int k = 0; k < 50; k++) begin
      logic lvl;
      lvl = (k % 2 == 0);
      btn_in = lvl;
      repeat (8) begin
        #1 btn_in = ~lvl;
        #1 btn_in = lvl;
      end
      @(posedge clk);
      #1;
      tick(9);
    end
    check("bounce_lo", btn_out, 0);
    tick(5);

    // Near miss: 24-cycle pulse is ignored, the next held step commits.
    btn_in = 1'b1;
    tick(24);
    btn_in = 1'b0;
    tick(6);
    check("nearmiss_lo", btn_out, 0);
    btn_in = 1'b1;
    s = cyc;
    push_exp(s + 28, 1'b1);
    tick(27);
    check("nearmiss_pre", btn_out, 0);
    tick(1);
    check("nearmiss_edge", btn_out, 1);
    tick(5);

    // Reset in the middle of PEND_LO drops the output at once.
    btn_in = 1'b0;
    tick(10);
    check("mid_pend", btn_out, 1);
    push_exp(cyc, 1'b0);
    rst = 1'b1;
    #1;
    check("mid_rst", btn_out, 0);
    btn_in = 1'b1;
    tick(3);
    check("mid_rst_hold", btn_out, 0);
    rst = 1'b0;
    s = cyc;
    push_exp(s + 28, 1'b1);
    tick(27);
    check("mid_post_pre", btn_out, 0);
    tick(1);
    check("mid_post_edge", btn_out, 1);
    tick(5);

    check("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
